// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester, serial-port and status signals of the TX arbiter
interface serial_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         dout;
  logic               wr_en;
  logic               writing_full;
  logic [3:0]         grant_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, req_last, writing_full,
    input  req_ready, dout, wr_en, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, writing_full,
    output req_ready, dout, wr_en, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - packet-atomic round-robin arbiter feeding the serial_port TX FIFO
module serial_tx_arbiter #(
  parameter int         N_REQ      = 4,
  parameter int         ADD_HEADER = 1,
  parameter logic [3:0] HDR_TAG    = 4'hA,
  parameter int         TIMEOUT    = 1024
) (
  input logic               clk,
  input logic               rst,
  serial_tx_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_SEND
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_rr_ptr;
  logic [3:0]    r_grant_id;
  logic [CW-1:0] r_stall_cnt;
  logic          r_timeout_err;

  logic [15:0]   w_valid16;
  logic [15:0]   w_last16;
  logic [127:0]  w_data128;
  logic [15:0]   w_ready16;
  logic          w_g_valid;
  logic          w_g_last;
  logic [7:0]    w_g_data;

  logic          w_pick_valid;
  logic [3:0]    w_pick_id;
  logic [4:0]    w_scan_idx;

  logic          w_wr_en;
  logic [7:0]    w_dout;
  logic          w_accept;
  logic          w_done;
  logic          w_abort;

  // Pad requester vectors to 16 so a 4-bit grant_id can index them for any N_REQ
  assign w_valid16 = 16'(bus.req_valid);
  assign w_last16  = 16'(bus.req_last);
  assign w_data128 = 128'(bus.req_data);
  assign w_g_valid = w_valid16[r_grant_id];
  assign w_g_last  = w_last16[r_grant_id];
  assign w_g_data  = w_data128[{r_grant_id, 3'b000} +: 8];

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = 4'd0;
    w_scan_idx   = 5'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_scan_idx = 5'(r_rr_ptr) + 5'(i);
      if (w_scan_idx >= 5'(N_REQ)) begin
        w_scan_idx = w_scan_idx - 5'(N_REQ);
      end
      if (!w_pick_valid && w_valid16[w_scan_idx[3:0]]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_scan_idx[3:0];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_dout       = 8'h00;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_next_state = (ADD_HEADER != 0) ? S_HEADER : S_SEND;
        end
      end
      S_HEADER: begin
        w_wr_en = !bus.writing_full;
        w_dout  = {HDR_TAG, r_grant_id};
        if (!bus.writing_full) begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        w_accept = w_g_valid && !bus.writing_full;
        w_wr_en  = w_accept;
        w_dout   = w_g_data;
        if (w_accept && w_g_last) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (!w_g_valid && !bus.writing_full &&
                     (r_stall_cnt == CW'(TIMEOUT - 2))) begin
          // This stall cycle brings the count to TIMEOUT-1
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= 4'(N_REQ - 1);
      r_grant_id    <= 4'd0;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_timeout_err <= w_abort;
      if ((r_state == S_IDLE) && w_pick_valid) begin
        r_grant_id <= w_pick_id;
      end
      if (w_done || w_abort) begin
        r_rr_ptr <= r_grant_id;
      end
      if ((r_state != S_SEND) || w_accept || bus.writing_full) begin
        r_stall_cnt <= '0;
      end else if (!w_g_valid) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign w_ready16       = 16'(w_accept) << r_grant_id;
  assign bus.req_ready   = w_ready16[N_REQ-1:0];
  assign bus.dout        = w_dout;
  assign bus.wr_en       = w_wr_en;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed bench: header and headerless arbiter instances
module tb_serial_tx_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  serial_tx_arbiter_if #(.N_REQ(4)) ifa ();
  serial_tx_arbiter_if #(.N_REQ(4)) ifb ();

  serial_tx_arbiter #(.N_REQ(4), .ADD_HEADER(1), .HDR_TAG(4'hA), .TIMEOUT(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  serial_tx_arbiter #(.N_REQ(4), .ADD_HEADER(0), .HDR_TAG(4'hA), .TIMEOUT(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic set_a(input int id, input logic v, input logic [7:0] d, input logic l);
    ifa.req_valid[id]       = v;
    ifa.req_data[id*8 +: 8] = d;
    ifa.req_last[id]        = l;
  endtask

  task automatic set_b(input int id, input logic v, input logic [7:0] d, input logic l);
    ifb.req_valid[id]       = v;
    ifb.req_data[id*8 +: 8] = d;
    ifb.req_last[id]        = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.writing_full = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.writing_full = 1'b0;
    nxt(); nxt(); look();
    chk("rst_wr_en", 32'(ifa.wr_en), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_ready", 32'(ifa.req_ready), 0);
    chk("rst_grant", 32'(ifa.grant_id), 0);
    chk("rst_terr", 32'(ifa.timeout_err), 0);

    // 1: header + three payload bytes from req0, one full cycle in HEADER
    nxt(); rst = 1'b0; set_a(0, 1'b1, 8'h11, 1'b0); look();
    chk("t1_idle_wr", 32'(ifa.wr_en), 0);
    chk("t1_idle_busy", 32'(ifa.busy), 0);
    nxt(); ifa.writing_full = 1'b1; look();
    chk("t1_hdr_busy", 32'(ifa.busy), 1);
    chk("t1_hdr_full_wr", 32'(ifa.wr_en), 0);
    chk("t1_grant", 32'(ifa.grant_id), 0);
    nxt(); ifa.writing_full = 1'b0; look();
    chk("t1_hdr_wr", 32'(ifa.wr_en), 1);
    chk("t1_hdr_dout", 32'(ifa.dout), 'hA0);
    chk("t1_hdr_rdy", 32'(ifa.req_ready), 0);
    nxt(); look();
    chk("t1_b0_wr", 32'(ifa.wr_en), 1);
    chk("t1_b0_dout", 32'(ifa.dout), 'h11);
    chk("t1_b0_rdy", 32'(ifa.req_ready), 1);
    nxt(); set_a(0, 1'b1, 8'h22, 1'b0); look();
    chk("t1_b1_dout", 32'(ifa.dout), 'h22);
    chk("t1_b1_rdy", 32'(ifa.req_ready), 1);
    nxt(); set_a(0, 1'b1, 8'h33, 1'b1); look();
    chk("t1_b2_dout", 32'(ifa.dout), 'h33);
    chk("t1_b2_rdy", 32'(ifa.req_ready), 1);
    nxt(); set_a(0, 1'b0, 8'h00, 1'b0); look();
    chk("t1_end_busy", 32'(ifa.busy), 0);
    chk("t1_end_wr", 32'(ifa.wr_en), 0);

    // 2: all four requesters with one-byte packets, from reset
    rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_a(i, 1'b1, 8'(i + 1), 1'b1);
    look();
    for (int k = 0; k < 5; k++) begin
      chk("t2_idle_busy", 32'(ifa.busy), 0);
      chk("t2_idle_wr", 32'(ifa.wr_en), 0);
      nxt(); look();
      chk("t2_grant", 32'(ifa.grant_id), 32'(k % 4));
      chk("t2_hdr_dout", 32'(ifa.dout), 32'('hA0 + (k % 4)));
      nxt(); look();
      chk("t2_rdy", 32'(ifa.req_ready), 32'(1 << (k % 4)));
      chk("t2_dout", 32'(ifa.dout), 32'((k % 4) + 1));
      nxt(); look();
    end
    ifa.req_valid = '0; ifa.req_last = '0;

    // 3: FIFO full for five cycles in the middle of req1's packet
    nxt(); set_a(1, 1'b1, 8'h31, 1'b0); look();
    chk("t3_idle_busy", 32'(ifa.busy), 0);
    nxt(); look();
    chk("t3_grant", 32'(ifa.grant_id), 1);
    chk("t3_hdr_dout", 32'(ifa.dout), 'hA1);
    nxt(); look();
    chk("t3_b0_dout", 32'(ifa.dout), 'h31);
    chk("t3_b0_rdy", 32'(ifa.req_ready), 2);
    nxt(); set_a(1, 1'b1, 8'h32, 1'b0); ifa.writing_full = 1'b1; look();
    for (int j = 0; j < 5; j++) begin
      chk("t3_full_wr", 32'(ifa.wr_en), 0);
      chk("t3_full_rdy", 32'(ifa.req_ready), 0);
      chk("t3_full_busy", 32'(ifa.busy), 1);
      chk("t3_full_terr", 32'(ifa.timeout_err), 0);
      if (j < 4) begin
        nxt(); look();
      end
    end
    nxt(); ifa.writing_full = 1'b0; look();
    chk("t3_b1_wr", 32'(ifa.wr_en), 1);
    chk("t3_b1_dout", 32'(ifa.dout), 'h32);
    chk("t3_b1_rdy", 32'(ifa.req_ready), 2);
    nxt(); set_a(1, 1'b1, 8'h33, 1'b1); look();
    chk("t3_b2_dout", 32'(ifa.dout), 'h33);
    chk("t3_b2_rdy", 32'(ifa.req_ready), 2);
    nxt(); set_a(1, 1'b0, 8'h00, 1'b0); look();
    chk("t3_end_busy", 32'(ifa.busy), 0);
    chk("t3_end_terr", 32'(ifa.timeout_err), 0);

    // 4: req2 stalls after two bytes; watchdog aborts, req3 is next
    nxt(); set_a(2, 1'b1, 8'h41, 1'b0); set_a(3, 1'b1, 8'h51, 1'b1); look();
    nxt(); look();
    chk("t4_grant2", 32'(ifa.grant_id), 2);
    chk("t4_hdr_dout", 32'(ifa.dout), 'hA2);
    nxt(); look();
    chk("t4_b0_dout", 32'(ifa.dout), 'h41);
    chk("t4_b0_rdy", 32'(ifa.req_ready), 4);
    nxt(); set_a(2, 1'b1, 8'h42, 1'b0); look();
    chk("t4_b1_dout", 32'(ifa.dout), 'h42);
    chk("t4_b1_rdy", 32'(ifa.req_ready), 4);
    nxt(); set_a(2, 1'b0, 8'h00, 1'b0); look();
    for (int s = 1; s <= 7; s++) begin
      chk("t4_stall_busy", 32'(ifa.busy), 1);
      chk("t4_stall_wr", 32'(ifa.wr_en), 0);
      chk("t4_stall_terr", 32'(ifa.timeout_err), 0);
      nxt(); look();
    end
    chk("t4_abort_busy", 32'(ifa.busy), 0);
    chk("t4_abort_terr", 32'(ifa.timeout_err), 1);
    chk("t4_abort_wr", 32'(ifa.wr_en), 0);
    nxt(); look();
    chk("t4_grant3", 32'(ifa.grant_id), 3);
    chk("t4_terr_pulse", 32'(ifa.timeout_err), 0);
    chk("t4_hdr3_dout", 32'(ifa.dout), 'hA3);
    nxt(); look();
    chk("t4_r3_dout", 32'(ifa.dout), 'h51);
    chk("t4_r3_rdy", 32'(ifa.req_ready), 8);
    nxt(); set_a(3, 1'b0, 8'h00, 1'b0); look();
    chk("t4_end_busy", 32'(ifa.busy), 0);

    // 5: reset in the middle of req1's packet
    nxt(); set_a(1, 1'b1, 8'h61, 1'b0); look();
    nxt(); look();
    chk("t5_grant1", 32'(ifa.grant_id), 1);
    nxt(); look();
    chk("t5_b0_dout", 32'(ifa.dout), 'h61);
    chk("t5_b0_rdy", 32'(ifa.req_ready), 2);
    nxt(); set_a(1, 1'b1, 8'h62, 1'b0); rst = 1'b1; look();
    nxt(); rst = 1'b0; set_a(0, 1'b1, 8'h71, 1'b1); look();
    chk("t5_rst_wr", 32'(ifa.wr_en), 0);
    chk("t5_rst_busy", 32'(ifa.busy), 0);
    chk("t5_rst_rdy", 32'(ifa.req_ready), 0);
    chk("t5_rst_grant", 32'(ifa.grant_id), 0);
    nxt(); look();
    chk("t5_grant0", 32'(ifa.grant_id), 0);
    chk("t5_hdr_dout", 32'(ifa.dout), 'hA0);
    nxt(); look();
    chk("t5_r0_dout", 32'(ifa.dout), 'h71);
    chk("t5_r0_rdy", 32'(ifa.req_ready), 1);
    nxt(); ifa.req_valid = '0; ifa.req_last = '0; look();

    // 6: headerless instance, single byte from req3
    nxt(); set_b(3, 1'b1, 8'h5A, 1'b1); look();
    chk("t6_idle_wr", 32'(ifb.wr_en), 0);
    chk("t6_idle_busy", 32'(ifb.busy), 0);
    nxt(); look();
    chk("t6_wr", 32'(ifb.wr_en), 1);
    chk("t6_dout", 32'(ifb.dout), 'h5A);
    chk("t6_rdy", 32'(ifb.req_ready), 8);
    chk("t6_grant", 32'(ifb.grant_id), 3);
    nxt(); set_b(3, 1'b0, 8'h00, 1'b0); look();
    chk("t6_end_wr", 32'(ifb.wr_en), 0);
    chk("t6_end_busy", 32'(ifb.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
